// File: rtl/sha3_pkg.sv
// Shared SHA-3 definitions: Keccak state layout, variant IDs and digest sizing.
// Used by both the input-side loader and the digest transmitter.
package sha3_pkg;

    typedef logic [4:0][4:0][63:0] keccak_state_t;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha3_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    function automatic int digest_bits(input logic [1:0] id);
        case (sha3_id_t'(id))
            SHA3_224: return 224;
            SHA3_256: return 256;
            SHA3_384: return 384;
            default:  return 512;
        endcase
    endfunction

    function automatic int n_beats(input logic [1:0] id, input int dw);
        return (digest_bits(id) + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/sha3_digest_tx.sv
// Streams the leading L bits of a Keccak state as an AXI-Stream packet,
// least-significant word of lane [0][0] first.
module sha3_digest_tx
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start,
    output logic                  s_ready,
    input  logic [1:0]            id_in,
    input  keccak_state_t         S_in,
    output logic                  M_TVALID,
    input  logic                  M_TREADY,
    output logic [DATA_WIDTH-1:0] M_TDATA,
    output logic                  M_TLAST,
    output logic [1:0]            M_TID
);

    tx_state_t       state_reg;
    logic [511:0]    buf_reg;
    logic [1:0]      id_reg;
    logic [5:0]      cnt_reg;

    logic [1599:0]   state_flat;
    logic [5:0]      last_idx;
    logic [DATA_WIDTH-1:0] beat_raw;
    logic [DATA_WIDTH-1:0] beat_mask;
    logic            handshake;
    logic            unused_state_bits;

    assign state_flat        = S_in;
    assign unused_state_bits = ^state_flat[1599:512];

    assign last_idx  = 6'(n_beats(id_reg, DATA_WIDTH) - 1);
    assign beat_raw  = buf_reg[int'(cnt_reg) * DATA_WIDTH +: DATA_WIDTH];

    // Bits at or beyond the digest length are forced to zero (224-bit tail at wide beats).
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
        assign beat_mask[gi] = (int'(cnt_reg) * DATA_WIDTH + gi) < digest_bits(id_reg);
    end

    assign s_ready   = (state_reg == IDLE);
    assign M_TVALID  = (state_reg == SEND);
    assign M_TDATA   = M_TVALID ? (beat_raw & beat_mask) : '0;
    assign M_TLAST   = M_TVALID && (cnt_reg == last_idx);
    assign M_TID     = id_reg;
    assign handshake = M_TVALID && M_TREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_reg <= IDLE;
            buf_reg   <= '0;
            id_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        buf_reg   <= state_flat[511:0];
                        id_reg    <= id_in;
                        cnt_reg   <= '0;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (cnt_reg == last_idx) begin
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + 6'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sha3_digest_tx.md
# sha3_digest_tx

AXI-Stream transmitter that returns the SHA-3 digest to the host after the Keccak permutation completes. It captures the leading 512 bits of the 1600-bit state on a start pulse. It then streams the digest as DATA_WIDTH-bit beats, and the digest length is selected by the SHA-3 variant ID (224/256/384/512). It mirrors the input-side stream loader: the state layout, the TID coding and the word ordering are identical, so host software can use one packing convention in both directions.

## Interface
- DATA_WIDTH, 16, beat width in bits; legal values 8, 16, 32, 64.
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse: permutation done, S_in valid this cycle.
- s_ready  out  1  high when the block can accept start (state IDLE).
- id_in  in  2  variant: 0=224, 1=256, 2=384, 3=512 digest bits.
- S_in  in  [4:0][4:0][63:0]  Keccak state; lane S_in[x][y] occupies flat bits 64*(5x+y) +: 64.
- M_TVALID  out  1  beat valid.
- M_TREADY  in  1  sink ready.
- M_TDATA  out  DATA_WIDTH  beat payload.
- M_TLAST  out  1  final beat of the digest.
- M_TID  out  2  copy of the latched id_in, constant for the whole packet.

## Operation
- FSM states: IDLE, SEND.
- IDLE: s_ready=1 and M_TVALID=0. When start=1, the block latches flat bits 511:0 (lanes [0][0..4] and [1][0..2]) into a 512-bit buffer, latches id_in, clears the beat counter and moves to SEND.
- start in SEND is ignored, with no effect on the buffer, the ID or the counter.
- Digest bits L = 224/256/384/512 by ID. Beat count N = ceil(L/DATA_WIDTH).
- For DW=16 the beat counts are 14/16/24/32. For DW=64 they are 4/4/6/8.
- Beat k carries buffer bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k], so beat 0 is the least-significant word of lane [0][0].
- Bits at index L or above are driven as 0. This matters only for L=224 with DW=64, where the upper 32 bits of beat 3 are zero.
- SEND: M_TVALID=1. On each handshake (M_TVALID & M_TREADY), the beat counter increments.
- M_TLAST=1 exactly when counter == N-1.
- A handshake with M_TLAST=1 moves the FSM to IDLE.
- Beat counter is 6 bits wide, which covers a maximum of 64 beats at DW=8. The counter never wraps within a packet.

## Timing
- Reset values: state IDLE, s_ready=1, M_TVALID=0, M_TLAST=0, M_TDATA=0, M_TID=0, counter=0, buffer=0.
- Latency: start sampled in cycle C gives first beat valid in cycle C+1.
- Beat rate: with M_TREADY held at 1, one beat per cycle. An N-beat digest completes in cycles C+1 to C+N.
- AXI-Stream rules:
  - Once M_TVALID is asserted it stays high until the handshake.
  - M_TDATA, M_TLAST and M_TID stay stable while M_TVALID & !M_TREADY.
  - M_TVALID never depends combinationally on M_TREADY.
- Completion: the final handshake occurs in cycle E. In cycle E+1 the state is IDLE and s_ready=1, and start is accepted from E+1 onward. This leaves a one-cycle gap minimum between packets.
- start at cycle E (during the final handshake) is ignored, because s_ready=0 in that cycle.
- Reset mid-packet: the next edge forces the reset values. The partial packet is abandoned with no TLAST, and the sink must tolerate this.
- Buffer updates only on start accepted in IDLE. S_in may change freely afterwards.

## Structure
- Shared package sha3_pkg:
  - typedef for the state type `[4:0][4:0][63:0]`.
  - enum for the variant ID (SHA3_224..SHA3_512).
  - function digest_bits(id) returning L.
  - function n_beats(id, dw) returning N.
- The input-side loader's padding offsets use the same package.
- Single module. No sub-module is warranted; the beat select is an indexed part-select of the buffer with a zero mask for the tail.

## Test plan
- DW=16, id=1, S_in[0][0]=64'h0123_4567_89AB_CDEF, M_TREADY=1:
  - Beats 0-3 are 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123.
  - 16 beats total; TLAST only on beat 15.
  - TID=1 on all beats.
  - s_ready returns 1 one cycle after the last beat.
- DW=16, id=3, M_TREADY toggling 1,0,0,1 repeatedly: 32 beats delivered in order, with TDATA/TLAST/TID held stable through every stall cycle.
- DW=64, id=0, all lanes 64'hFFFF_FFFF_FFFF_FFFF: 4 beats. Beat 3 is 64'h0000_0000_FFFF_FFFF with TLAST=1.
- start pulsed with id=2 and a new S_in while on beat 5 of an id=1 packet: the current packet finishes unchanged with 16 beats and TID=1, and no second packet follows.
- ARESETn low for one cycle during beat 7: the next cycle shows M_TVALID=0 and s_ready=1. A fresh start then produces a complete packet from beat 0.
- Back-to-back: start issued at E+1 after a TLAST handshake at E. The second packet's first beat is valid at E+2, carrying the new data and the new ID.
